wb_mem_slave: RTL

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

---
 rtl/wb_mem_slave.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: pipelined Wishbone memory slave with a fixed ack latency.
//
// A single-port word memory sits behind a Wishbone pipelined slave port.
// Every accepted request (read or write) travels down a G_LATENCY-stage
// shift pipeline and produces exactly one ack G_LATENCY cycles after it was
// accepted. An outstanding-request counter throttles acceptance through
// wb_stall_o. Dropping wb_cyc_i aborts the cycle and discards pending acks;
// writes that were already accepted stay in memory.
//
// Parameters:
//   G_ADDR_SIZE        address bits decoded (memory depth 2**G_ADDR_SIZE)
//   G_DATA_SIZE        word width in bits
//   G_LATENCY          cycles from acceptance to ack, 1..4
//   G_MAX_OUTSTANDING  accepted-but-unacknowledged limit, 1..G_LATENCY
//
// Ports:
//   clk_i       clock, all logic on the rising edge
//   rst_i       synchronous active-high reset (memory contents are kept)
//   wb_cyc_i    bus cycle active; low aborts all pending requests
//   wb_stb_i    request strobe
//   wb_stall_o  request cannot be accepted this cycle
//   wb_addr_i   word address, only the low G_ADDR_SIZE bits are decoded
//   wb_we_i     1 = write, 0 = read
//   wb_data_i   write data
//   wb_ack_o    one pulse per accepted request
//   wb_data_o   read data during a read ack, zero otherwise
module wb_mem_slave #(
  parameter int G_ADDR_SIZE       = 8,
  parameter int G_DATA_SIZE       = 16,
  parameter int G_LATENCY         = 2,
  parameter int G_MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic                   wb_stall_o,
  input  logic [15:0]            wb_addr_i,
  input  logic                   wb_we_i,
  input  logic [G_DATA_SIZE-1:0] wb_data_i,
  output logic                   wb_ack_o,
  output logic [G_DATA_SIZE-1:0] wb_data_o
);

  localparam int CNT_W = $clog2(G_MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(G_MAX_OUTSTANDING);

  logic [G_DATA_SIZE-1:0] mem [2**G_ADDR_SIZE];

  logic [G_ADDR_SIZE-1:0] word_addr;
  logic                   accept;
  logic                   flush;
  logic                   last_valid;
  logic                   last_read;
  logic [G_DATA_SIZE-1:0] last_data;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;

  // Upper address bits are ignored, so addresses alias modulo the depth.
  assign word_addr = wb_addr_i[G_ADDR_SIZE-1:0];

  if (G_ADDR_SIZE < 16) begin : g_addr_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^wb_addr_i[15:G_ADDR_SIZE];
  end

  // Reset and bus-cycle abort both wipe the pending requests.
  assign flush = rst_i || !wb_cyc_i;

  // Stall depends on registered state only. A request leaving the pipeline
  // this cycle frees a slot, so a full counter does not stall in that case.
  assign wb_stall_o = !rst_i && (count_reg == CNT_MAX) && !last_valid;
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o && !rst_i;

  // Ack is gated by cyc/rst so nothing escapes during an abort or reset.
  assign wb_ack_o  = wb_cyc_i && !rst_i && last_valid;
  assign wb_data_o = (wb_ack_o && last_read) ? last_data : '0;

  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i) begin
      mem[word_addr] <= wb_data_i;
    end
  end

  // Latency pipeline. Stage 0 holds the registered memory read, so the read
  // reflects memory as it stood at the accepting edge (writes accepted on
  // earlier edges are visible).
  for (genvar gi = 0; gi < G_LATENCY; gi++) begin : g_stage
    logic                   valid_reg;
    logic                   read_reg;
    logic [G_DATA_SIZE-1:0] data_reg;

    if (gi == 0) begin : g_head
      always_ff @(posedge clk_i) begin
        if (flush) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= accept;
        end
        if (accept) begin
          read_reg <= !wb_we_i;
          data_reg <= mem[word_addr];
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk_i) begin
        if (flush) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= g_stage[gi-1].valid_reg;
        end
        read_reg <= g_stage[gi-1].read_reg;
        data_reg <= g_stage[gi-1].data_reg;
      end
    end
  end

  assign last_valid = g_stage[G_LATENCY-1].valid_reg;
  assign last_read  = g_stage[G_LATENCY-1].read_reg;
  assign last_data  = g_stage[G_LATENCY-1].data_reg;

  // Outstanding requests: acceptance and ack in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    if (accept && !wb_ack_o) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!accept && wb_ack_o) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule
